// File: rtl/uart_cmd_queue.sv
// UART byte capture with rising-edge arrival detection, optional command filter,
// a show-ahead FIFO with sticky overflow, and a one-hot LED decode of the last byte.
module uart_cmd_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int FILTER = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   rx_valid,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [31:0]            rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [3:0]             leds
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              prev_valid;
  logic [31:0]       rx_ext;
  logic [3:0]        led_code;
  logic              arrival;
  logic              accept;
  logic              push;
  logic              pop;
  logic              ovf_set;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rx_ext = '0;
    rx_ext[DATA_W-1:0] = rx_data;
    case (rx_ext)
      32'h55:  led_code = 4'b0001;
      32'h44:  led_code = 4'b0010;
      32'h4C:  led_code = 4'b0100;
      32'h52:  led_code = 4'b1000;
      default: led_code = 4'b0000;
    endcase
  end

  // A non-zero decode doubles as "is a command byte".
  assign arrival = rx_valid && !prev_valid;
  assign accept  = arrival && ((FILTER == 0) || (led_code != 4'b0000));
  assign pop     = rd_en && !empty;
  assign push    = accept && (!full || pop);
  assign ovf_set = accept && full && !pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    rd_data = '0;
    if (!empty) rd_data[DATA_W-1:0] = mem[rd_ptr];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      prev_valid <= 1'b0;
      overflow   <= 1'b0;
      leds       <= 4'b0000;
    end else begin
      prev_valid <= rx_valid;
      if (arrival) leds <= led_code;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh overflow wins over a simultaneous clear.
      if (ovf_set) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

endmodule
